// File: rtl/graphics_pkg.sv
// graphics_pkg: canvas and spritesheet geometry, the sprite descriptor, issuer states and the animation wrap helper.
// These values are shared with the renderer.
package graphics_pkg;
  localparam int CANVAS_W     = 1280;
  localparam int CANVAS_H     = 720;
  localparam int SHEET_FRAMES = 512;
  localparam int X_W          = $clog2(CANVAS_W);
  localparam int Y_W          = $clog2(CANVAS_H);
  localparam int FRAME_W      = $clog2(SHEET_FRAMES);
  typedef struct packed {
    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
    logic [FRAME_W-1:0] frame;
  } sprite_desc_t;
  typedef enum logic [1:0] {IDLE, SCAN, ISSUE} issuer_state_t;
  // Returns the last valid phase for an animation length. A length of 0 counts as 1.
  function automatic logic [3:0] last_phase(input logic [3:0] nf);
    return nf == 4'd0 ? 4'd0 : nf - 4'd1;
  endfunction
endpackage

// File: rtl/sprite_table.sv
// sprite_table: entity register file with a write port, per-entry animation phase, and a combinational read by index.
// Ports:
//   clk_pixel, sys_rst_n     clock and asynchronous active-low reset
//   tick                     new-frame strobe; it drives the animation divider
//   we, widx, w*             entry write; a write also clears that entry's phase
//   ridx -> ractive, rx, ry, rframe   read port; rframe is base plus phase
module sprite_table import graphics_pkg::*; #(
  parameter int N  = 16,
  parameter int XW = 11,
  parameter int YW = 10,
  parameter int FW = 9,
  parameter int AD = 4,
  parameter int IW = $clog2(N)
) (
  input  logic          clk_pixel,
  input  logic          sys_rst_n,
  input  logic          tick,
  input  logic          we,
  input  logic [IW-1:0] widx,
  input  logic          wactive,
  input  logic [XW-1:0] wx,
  input  logic [YW-1:0] wy,
  input  logic [FW-1:0] wbase,
  input  logic [3:0]    wnf,
  input  logic [IW-1:0] ridx,
  output logic          ractive,
  output logic [XW-1:0] rx,
  output logic [YW-1:0] ry,
  output logic [FW-1:0] rframe
);
  localparam int DW = AD > 1 ? $clog2(AD) : 1;
  logic          active [N];
  logic [XW-1:0] x      [N];
  logic [YW-1:0] y      [N];
  logic [FW-1:0] base   [N];
  logic [3:0]    nf     [N];
  logic [3:0]    phase  [N];
  logic [DW-1:0] div;
  logic          step;
  // Phases advance only on the frame where the divider wraps.
  assign step    = tick && div == DW'(AD - 1);
  assign ractive = active[ridx];
  assign rx      = x[ridx];
  assign ry      = y[ridx];
  assign rframe  = base[ridx] + FW'(phase[ridx]);
  always_ff @(posedge clk_pixel or negedge sys_rst_n)
    if (!sys_rst_n) begin
      div <= '0;
      for (int i = 0; i < N; i++) begin
        active[i] <= 1'b0;
        x[i]      <= '0;
        y[i]      <= '0;
        base[i]   <= '0;
        nf[i]     <= '0;
        phase[i]  <= '0;
      end
    end else begin
      if (tick) div <= step ? '0 : div + 1'b1;
      // A write takes priority over a phase step on the same entry.
      for (int i = 0; i < N; i++)
        if (we && widx == IW'(i)) begin
          active[i] <= wactive;
          x[i]      <= wx;
          y[i]      <= wy;
          base[i]   <= wbase;
          nf[i]     <= wnf;
          phase[i]  <= '0;
        end else if (step && active[i])
          phase[i] <= phase[i] == last_phase(nf[i]) ? '0 : phase[i] + 1'b1;
    end
endmodule

// File: rtl/sprite_issuer.sv
// sprite_issuer: on every frame change, walks the entity table and issues one descriptor per active entity.
// Ports:
//   clk_pixel, sys_rst_n                  clock and asynchronous active-low reset
//   frame_count                           free-running counter; any change starts a new frame
//   ent_*                                 table write port from the game logic
//   sprite_valid/ready, sprite_x/y/frame_number   descriptor handshake to the renderer
//   sweep_done                            one-cycle pulse after a completed sweep
//   overrun                               sticky; a frame arrived before a sweep finished
module sprite_issuer import graphics_pkg::*; #(
  parameter int MAX_SPRITES = 16,
  parameter int WIDTH       = CANVAS_W,
  parameter int HEIGHT      = CANVAS_H,
  parameter int NUM_FRAMES  = SHEET_FRAMES,
  parameter int ANIM_DIV    = 4,
  localparam int IW = $clog2(MAX_SPRITES),
  localparam int XW = $clog2(WIDTH),
  localparam int YW = $clog2(HEIGHT),
  localparam int FW = $clog2(NUM_FRAMES)
) (
  input  logic          clk_pixel,
  input  logic          sys_rst_n,
  input  logic [5:0]    frame_count,
  input  logic          ent_we,
  input  logic [IW-1:0] ent_idx,
  input  logic          ent_active,
  input  logic [XW-1:0] ent_x,
  input  logic [YW-1:0] ent_y,
  input  logic [FW-1:0] ent_base_frame,
  input  logic [3:0]    ent_num_frames,
  input  logic          sprite_ready,
  output logic          sprite_valid,
  output logic [XW-1:0] sprite_x,
  output logic [YW-1:0] sprite_y,
  output logic [FW-1:0] sprite_frame_number,
  output logic          sweep_done,
  output logic          overrun
);
  issuer_state_t state, state_nx;
  logic [5:0]    prev_fc;
  logic          tick, pend, pend_nx, valid_nx, done_nx, overrun_nx, last, accept;
  logic [IW-1:0] idx, idx_nx;
  logic [XW-1:0] x_nx, rx;
  logic [YW-1:0] y_nx, ry;
  logic [FW-1:0] f_nx, rframe;
  logic          ractive;
  assign last   = idx == IW'(MAX_SPRITES - 1);
  assign accept = sprite_valid && sprite_ready;
  sprite_table #(
    .N(MAX_SPRITES), .XW(XW), .YW(YW), .FW(FW), .AD(ANIM_DIV), .IW(IW)
  ) u_table (
    .clk_pixel(clk_pixel),
    .sys_rst_n(sys_rst_n),
    .tick(tick),
    .we(ent_we),
    .widx(ent_idx),
    .wactive(ent_active),
    .wx(ent_x),
    .wy(ent_y),
    .wbase(ent_base_frame),
    .wnf(ent_num_frames),
    .ridx(idx),
    .ractive(ractive),
    .rx(rx),
    .ry(ry),
    .rframe(rframe)
  );
  always_ff @(posedge clk_pixel or negedge sys_rst_n)
    if (!sys_rst_n) begin
      prev_fc             <= '0;
      tick                <= 1'b0;
      state               <= IDLE;
      idx                 <= '0;
      pend                <= 1'b0;
      sprite_valid        <= 1'b0;
      sprite_x            <= '0;
      sprite_y            <= '0;
      sprite_frame_number <= '0;
      sweep_done          <= 1'b0;
      overrun             <= 1'b0;
    end else begin
      prev_fc             <= frame_count;
      tick                <= frame_count != prev_fc;
      state               <= state_nx;
      idx                 <= idx_nx;
      pend                <= pend_nx;
      sprite_valid        <= valid_nx;
      sprite_x            <= x_nx;
      sprite_y            <= y_nx;
      sprite_frame_number <= f_nx;
      sweep_done          <= done_nx;
      overrun             <= overrun_nx;
    end
  // pend holds a restart request that arrives during a stalled ISSUE until the handshake completes.
  always_comb begin
    state_nx   = state;
    idx_nx     = idx;
    pend_nx    = pend;
    valid_nx   = sprite_valid;
    x_nx       = sprite_x;
    y_nx       = sprite_y;
    f_nx       = sprite_frame_number;
    done_nx    = 1'b0;
    overrun_nx = overrun || (tick && state != IDLE);
    case (state)
      IDLE: if (tick) begin
        state_nx = SCAN;
        idx_nx   = '0;
      end
      SCAN:
        if (tick) idx_nx = '0;
        else if (ractive) begin
          state_nx = ISSUE;
          valid_nx = 1'b1;
          x_nx     = rx;
          y_nx     = ry;
          f_nx     = rframe;
        end else if (last) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end else idx_nx = idx + 1'b1;
      ISSUE:
        if (accept) begin
          valid_nx = 1'b0;
          pend_nx  = 1'b0;
          if (pend || tick) begin
            state_nx = SCAN;
            idx_nx   = '0;
          end else if (last) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end else begin
            state_nx = SCAN;
            idx_nx   = idx + 1'b1;
          end
        end else if (tick) pend_nx = 1'b1;
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_sprite_issuer.sv
// tb_sprite_issuer: randomized self-checking bench comparing sprite_issuer against a frame-level table model.
module tb_sprite_issuer;
  import graphics_pkg::*;
  localparam int N  = 16;
  localparam int AD = 3;
  localparam int IW = $clog2(N);
  logic               clk_pixel      = 1'b0;
  logic               sys_rst_n      = 1'b0;
  logic [5:0]         frame_count    = '0;
  logic               ent_we         = 1'b0;
  logic [IW-1:0]      ent_idx        = '0;
  logic               ent_active     = 1'b0;
  logic [X_W-1:0]     ent_x          = '0;
  logic [Y_W-1:0]     ent_y          = '0;
  logic [FRAME_W-1:0] ent_base_frame = '0;
  logic [3:0]         ent_num_frames = '0;
  logic               sprite_ready   = 1'b0;
  logic               sprite_valid, sweep_done, overrun;
  logic [X_W-1:0]     sprite_x;
  logic [Y_W-1:0]     sprite_y;
  logic [FRAME_W-1:0] sprite_frame_number;
  int errors = 0, checks = 0, rmode = 0, done_cnt = 0, m_div = 0;
  sprite_desc_t got_q[$], exp_q[$], old_q[$];
  bit m_act[N];
  int m_x[N], m_y[N], m_base[N], m_nf[N], m_ph[N];

  sprite_issuer #(
    .MAX_SPRITES(N), .WIDTH(CANVAS_W), .HEIGHT(CANVAS_H), .NUM_FRAMES(SHEET_FRAMES), .ANIM_DIV(AD)
  ) dut (
    .clk_pixel(clk_pixel), .sys_rst_n(sys_rst_n), .frame_count(frame_count),
    .ent_we(ent_we), .ent_idx(ent_idx), .ent_active(ent_active), .ent_x(ent_x), .ent_y(ent_y),
    .ent_base_frame(ent_base_frame), .ent_num_frames(ent_num_frames), .sprite_ready(sprite_ready),
    .sprite_valid(sprite_valid), .sprite_x(sprite_x), .sprite_y(sprite_y),
    .sprite_frame_number(sprite_frame_number), .sweep_done(sweep_done), .overrun(overrun)
  );

  always #5 clk_pixel = ~clk_pixel;

  initial forever begin
    @(posedge clk_pixel);
    #1 sprite_ready = rmode == 0 ? 1'b1 : rmode == 1 ? 1'($urandom_range(1)) : 1'b0;
  end

  always @(negedge clk_pixel) begin
    if (sprite_valid && sprite_ready) got_q.push_back(sprite_desc_t'{sprite_x, sprite_y, sprite_frame_number});
    if (sweep_done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input int i, input bit a, input int x, input int y, input int b, input int nf);
    @(posedge clk_pixel); #1;
    ent_we = 1'b1; ent_idx = IW'(i); ent_active = a; ent_x = X_W'(x); ent_y = Y_W'(y);
    ent_base_frame = FRAME_W'(b); ent_num_frames = 4'(nf);
    @(posedge clk_pixel); #1;
    ent_we = 1'b0;
    m_act[i] = a; m_x[i] = x; m_y[i] = y; m_base[i] = b; m_nf[i] = nf; m_ph[i] = 0;
  endtask

  task automatic clear_table();
    for (int i = 0; i < N; i++) wr(i, 0, 0, 0, 0, 0);
  endtask

  // A frame advances the animation divider; every AD frames each active entity steps its phase.
  task automatic new_frame();
    @(posedge clk_pixel); #1;
    frame_count = frame_count + 6'd1;
    m_div = (m_div + 1) % AD;
    if (m_div == 0)
      for (int i = 0; i < N; i++)
        if (m_act[i]) m_ph[i] = (m_ph[i] + 1) % (m_nf[i] == 0 ? 1 : m_nf[i]);
  endtask

  function automatic void build_exp();
    exp_q.delete();
    for (int i = 0; i < N; i++)
      if (m_act[i])
        exp_q.push_back(sprite_desc_t'{X_W'(m_x[i]), Y_W'(m_y[i]), FRAME_W'((m_base[i] + m_ph[i]) % SHEET_FRAMES)});
  endfunction

  task automatic start_frame();
    got_q.delete();
    done_cnt = 0;
    new_frame();
    build_exp();
  endtask

  task automatic wait_valid(input string tag, output int n);
    n = 0;
    do begin
      @(posedge clk_pixel); @(negedge clk_pixel); n++;
    end while (!sprite_valid && n < 100);
    chk({tag, "_valid"}, 32'(sprite_valid), 1);
  endtask

  task automatic cmp_list(input string tag, input int off);
    for (int i = 0; i < exp_q.size() && off + i < got_q.size(); i++) begin
      chk($sformatf("%s_x%0d", tag, i), 32'(got_q[off+i].x), 32'(exp_q[i].x));
      chk($sformatf("%s_y%0d", tag, i), 32'(got_q[off+i].y), 32'(exp_q[i].y));
      chk($sformatf("%s_f%0d", tag, i), 32'(got_q[off+i].frame), 32'(exp_q[i].frame));
    end
  endtask

  task automatic finish_frame(input string tag);
    int n = 0;
    while (done_cnt == 0 && n < 3000) begin @(negedge clk_pixel); n++; end
    repeat (4) @(negedge clk_pixel);
    chk({tag, "_done"}, 32'(done_cnt), 1);
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    cmp_list(tag, 0);
  endtask

  initial begin
    int n, p;
    sprite_desc_t snap;
    #12;
    chk("rst_valid", 32'(sprite_valid), 0);
    chk("rst_done", 32'(sweep_done), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_payload", 32'({sprite_x, sprite_y, sprite_frame_number}), 0);
    @(posedge clk_pixel); #1 sys_rst_n = 1'b1;

    // two active entries, ready always high
    rmode = 0;
    wr(2, 1, 100, 50, 8, 4);
    wr(5, 1, 640, 360, 100, 2);
    start_frame();
    wait_valid("basic", n);
    chk("basic_latency", 32'(n), 5);
    finish_frame("basic");

    // animation over several frames, throttled ready
    clear_table();
    wr(0, 1, 10, 20, 8, 3);
    rmode = 1;
    for (int f = 0; f < 7; f++) begin
      start_frame();
      finish_frame($sformatf("anim%0d", f));
    end

    // renderer stalled for 20 cycles
    clear_table();
    wr(2, 1, 100, 50, 8, 4);
    wr(5, 1, 640, 360, 100, 2);
    rmode = 2;
    start_frame();
    wait_valid("stall", n);
    snap = sprite_desc_t'{sprite_x, sprite_y, sprite_frame_number};
    n = 0;
    repeat (20) begin
      @(negedge clk_pixel);
      if (!sprite_valid || sprite_desc_t'{sprite_x, sprite_y, sprite_frame_number} != snap) n++;
    end
    chk("stall_unstable_cycles", 32'(n), 0);
    chk("stall_xfers", 32'(got_q.size()), 0);
    rmode = 0;
    finish_frame("stall");
    chk("pre_overrun", 32'(overrun), 0);

    // frame change in the middle of a throttled sweep
    clear_table();
    for (int i = 0; i < 6; i++) wr(i * 2 + 1, 1, 30 * i + 5, 7 * i + 3, 40 + i, i + 1);
    rmode = 1;
    start_frame();
    old_q = exp_q;
    n = 0;
    while (got_q.size() < 2 && n < 500) begin @(negedge clk_pixel); n++; end
    new_frame();
    build_exp();
    n = 0;
    while (done_cnt == 0 && n < 3000) begin @(negedge clk_pixel); n++; end
    repeat (4) @(negedge clk_pixel);
    chk("ovr_flag", 32'(overrun), 1);
    chk("ovr_done", 32'(done_cnt), 1);
    p = got_q.size() - exp_q.size();
    chk("ovr_prefix_len_ok", 32'(p >= 2 && p <= old_q.size()), 1);
    for (int i = 0; i < p && i < old_q.size(); i++)
      chk($sformatf("ovr_old%0d", i), 32'(got_q[i]), 32'(old_q[i]));
    cmp_list("ovr_new", p < 0 ? 0 : p);

    // rewrite of the entry currently being issued
    clear_table();
    wr(3, 1, 300, 200, 20, 5);
    wr(9, 1, 900, 100, 60, 2);
    rmode = 2;
    start_frame();
    wait_valid("wiss", n);
    wr(3, 1, 700, 200, 20, 5);
    chk("wiss_hold_x", 32'(sprite_x), 300);
    chk("wiss_hold_valid", 32'(sprite_valid), 1);
    rmode = 0;
    finish_frame("wiss");
    start_frame();
    finish_frame("wiss_next");

    // random table contents and renderer throttling
    for (int r = 0; r < 10; r++) begin
      repeat ($urandom_range(0, 4))
        wr($urandom_range(0, N - 1), $urandom_range(0, 3) != 0, $urandom_range(0, CANVAS_W - 1),
           $urandom_range(0, CANVAS_H - 1), $urandom_range(0, SHEET_FRAMES - 1), $urandom_range(0, 15));
      rmode = $urandom_range(0, 1);
      start_frame();
      finish_frame($sformatf("rnd%0d", r));
    end

    // asynchronous reset while a descriptor is stalled
    clear_table();
    wr(4, 1, 11, 22, 33, 2);
    rmode = 2;
    start_frame();
    wait_valid("arst", n);
    #2 sys_rst_n = 1'b0;
    frame_count = '0;
    #1;
    chk("arst_valid", 32'(sprite_valid), 0);
    chk("arst_overrun", 32'(overrun), 0);
    chk("arst_x", 32'(sprite_x), 0);
    for (int i = 0; i < N; i++) begin m_act[i] = 0; m_ph[i] = 0; end
    m_div = 0;
    @(posedge clk_pixel); @(posedge clk_pixel); #1 sys_rst_n = 1'b1;
    rmode = 0;
    start_frame();
    repeat (60) @(negedge clk_pixel);
    chk("arst_xfers", 32'(got_q.size()), 32'(exp_q.size()));
    chk("arst_done", 32'(done_cnt), 1);
    chk("arst_overrun_after", 32'(overrun), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
